// File: rtl/tlul_txn_monitor.sv
// Passive TileLink-UL monitor: per-source pending tracking, event counters, worst-case latency, first-violation latch.
// Optional SVA checks are compiled in when TLUL_TXN_MONITOR_ASSERT_EN is defined.
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [7:0]  d_source;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module tlul_txn_monitor #(
    parameter int NumSrc        = 4,
    parameter int TimeoutCycles = 1024,
    parameter int CntW          = 32,
    parameter int LatW          = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tlul_pkg::tl_h2d_t  tl_h2d_i,
    input  tlul_pkg::tl_d2h_t  tl_d2h_i,
    input  logic               clear_i,
    output logic [NumSrc-1:0]  outstanding_o,
    output logic [CntW-1:0]    num_req_o,
    output logic [CntW-1:0]    num_rsp_o,
    output logic [CntW-1:0]    num_err_rsp_o,
    output logic [LatW-1:0]    max_latency_o,
    output logic               violation_o,
    output logic [2:0]         violation_code_o,
    output logic               timeout_o
);
    localparam int SrcW = (NumSrc > 1) ? $clog2(NumSrc) : 1;
    localparam int AFW  = 3 + 32 + 8 + 2 + 4 + 32;
    localparam logic [LatW-1:0] LAT_MAX = '1;
    localparam logic [CntW-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} src_state_e;

    src_state_e       r_state [NumSrc];
    logic [LatW-1:0]  r_lat   [NumSrc];
    logic             r_a_hold;
    logic [AFW-1:0]   r_a_snap;
    logic [CntW-1:0]  r_num_req, r_num_rsp, r_num_err;
    logic [LatW-1:0]  r_max_lat;
    logic             r_viol, r_timeout;
    logic [2:0]       r_code;

    src_state_e       w_state_nxt [NumSrc];
    logic [LatW-1:0]  w_lat_nxt   [NumSrc];
    logic [NumSrc-1:0] w_req_hit, w_rsp_hit, w_to_hit;
    logic             w_done;
    logic [LatW-1:0]  w_cand;
    logic [2:0]       w_code;

    logic             w_req_fire, w_rsp_fire, w_req_legal, w_rsp_legal, w_same_src;
    logic [SrcW-1:0]  w_a_idx, w_d_idx;
    logic [AFW-1:0]   w_a_fields;
    logic             w_v_illegal, w_v_dup, w_v_unexp, w_v_unstable, w_v_timeout;

    assign w_req_fire  = tl_h2d_i.a_valid & tl_d2h_i.a_ready;
    assign w_rsp_fire  = tl_d2h_i.d_valid & tl_h2d_i.d_ready;
    assign w_req_legal = 32'(tl_h2d_i.a_source) < NumSrc;
    assign w_rsp_legal = 32'(tl_d2h_i.d_source) < NumSrc;
    assign w_a_idx     = tl_h2d_i.a_source[SrcW-1:0];
    assign w_d_idx     = tl_d2h_i.d_source[SrcW-1:0];
    assign w_same_src  = tl_h2d_i.a_source == tl_d2h_i.d_source;
    assign w_a_fields  = {tl_h2d_i.a_opcode, tl_h2d_i.a_address, tl_h2d_i.a_source,
                          tl_h2d_i.a_size, tl_h2d_i.a_mask, tl_h2d_i.a_data};

    // A same-cycle request from the responding source turns an otherwise bad event into a handover.
    assign w_v_illegal  = (w_req_fire & ~w_req_legal) | (w_rsp_fire & ~w_rsp_legal);
    assign w_v_dup      = w_req_fire & w_req_legal & (r_state[w_a_idx] == ST_PENDING)
                          & ~(w_rsp_fire & w_same_src);
    assign w_v_unexp    = w_rsp_fire & w_rsp_legal & (r_state[w_d_idx] == ST_IDLE)
                          & ~(w_req_fire & w_same_src);
    assign w_v_unstable = r_a_hold & (~tl_h2d_i.a_valid | (w_a_fields != r_a_snap));
    assign w_v_timeout  = |w_to_hit;

    always_comb begin
        w_done = 1'b0;
        w_cand = '0;
        for (int s = 0; s < NumSrc; s++) begin
            w_req_hit[s]   = w_req_fire & w_req_legal & (w_a_idx == SrcW'(s));
            w_rsp_hit[s]   = w_rsp_fire & w_rsp_legal & (w_d_idx == SrcW'(s));
            w_to_hit[s]    = (r_state[s] == ST_PENDING) && (32'(r_lat[s]) == 32'(TimeoutCycles - 1));
            w_state_nxt[s] = r_state[s];
            w_lat_nxt[s]   = r_lat[s];
            if (w_rsp_hit[s] && r_state[s] == ST_PENDING) begin
                w_done = 1'b1;
                w_cand = (r_lat[s] == LAT_MAX) ? LAT_MAX : r_lat[s] + LatW'(1);
            end else if (w_rsp_hit[s] && w_req_hit[s]) begin
                w_done = 1'b1;
                w_cand = '0;
            end
            if (w_req_hit[s] && w_rsp_hit[s]) begin
                w_lat_nxt[s] = '0;
            end else if (w_req_hit[s]) begin
                w_state_nxt[s] = ST_PENDING;
                w_lat_nxt[s]   = '0;
            end else if (w_rsp_hit[s]) begin
                w_state_nxt[s] = ST_IDLE;
                w_lat_nxt[s]   = '0;
            end else if (r_state[s] == ST_PENDING && r_lat[s] != LAT_MAX) begin
                w_lat_nxt[s] = r_lat[s] + LatW'(1);
            end
        end
    end

    always_comb begin
        w_code = 3'd0;
        if (w_v_illegal)       w_code = 3'd1;
        else if (w_v_dup)      w_code = 3'd2;
        else if (w_v_unexp)    w_code = 3'd3;
        else if (w_v_unstable) w_code = 3'd4;
        else if (w_v_timeout)  w_code = 3'd5;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NumSrc; s++) begin
                r_state[s] <= ST_IDLE;
                r_lat[s]   <= '0;
            end
            r_a_hold  <= 1'b0;
            r_a_snap  <= '0;
            r_num_req <= '0;
            r_num_rsp <= '0;
            r_num_err <= '0;
            r_max_lat <= '0;
            r_viol    <= 1'b0;
            r_code    <= 3'd0;
            r_timeout <= 1'b0;
        end else begin
            for (int s = 0; s < NumSrc; s++) begin
                r_state[s] <= w_state_nxt[s];
                r_lat[s]   <= w_lat_nxt[s];
            end
            r_a_hold <= tl_h2d_i.a_valid & ~tl_d2h_i.a_ready;
            r_a_snap <= w_a_fields;
            // Clear wins over every event in the same cycle; source tracking keeps running.
            if (clear_i) begin
                r_num_req <= '0;
                r_num_rsp <= '0;
                r_num_err <= '0;
                r_max_lat <= '0;
                r_viol    <= 1'b0;
                r_code    <= 3'd0;
                r_timeout <= 1'b0;
            end else begin
                if (w_req_fire && r_num_req != CNT_MAX) r_num_req <= r_num_req + CntW'(1);
                if (w_rsp_fire && r_num_rsp != CNT_MAX) r_num_rsp <= r_num_rsp + CntW'(1);
                if (w_rsp_fire && tl_d2h_i.d_error && r_num_err != CNT_MAX)
                    r_num_err <= r_num_err + CntW'(1);
                if (w_done && w_cand > r_max_lat) r_max_lat <= w_cand;
                if (w_code != 3'd0 && !r_viol) begin
                    r_viol <= 1'b1;
                    r_code <= w_code;
                end
                if (w_v_timeout) r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NumSrc; s++) outstanding_o[s] = (r_state[s] == ST_PENDING);
    end

    assign num_req_o        = r_num_req;
    assign num_rsp_o        = r_num_rsp;
    assign num_err_rsp_o    = r_num_err;
    assign max_latency_o    = r_max_lat;
    assign violation_o      = r_viol;
    assign violation_code_o = r_code;
    assign timeout_o        = r_timeout;

`ifdef TLUL_TXN_MONITOR_ASSERT_EN
    logic [31:0] r_cycle;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_cycle <= '0;
        else       r_cycle <= r_cycle + 32'd1;
    end

    a_illegal_src: assert property (@(posedge clk_i) disable iff (rst_i) !w_v_illegal)
        else $error("ILLEGAL_SRC a_src=%0d d_src=%0d cycle=%0d", tl_h2d_i.a_source, tl_d2h_i.d_source, r_cycle);
    a_dup_src: assert property (@(posedge clk_i) disable iff (rst_i) !w_v_dup)
        else $error("DUP_SRC src=%0d cycle=%0d", tl_h2d_i.a_source, r_cycle);
    a_unexp_rsp: assert property (@(posedge clk_i) disable iff (rst_i) !w_v_unexp)
        else $error("UNEXPECTED_RSP src=%0d cycle=%0d", tl_d2h_i.d_source, r_cycle);
    a_unstable: assert property (@(posedge clk_i) disable iff (rst_i) !w_v_unstable)
        else $error("A_UNSTABLE src=%0d cycle=%0d", tl_h2d_i.a_source, r_cycle);
    a_timeout: assert property (@(posedge clk_i) disable iff (rst_i) !w_v_timeout)
        else $error("TIMEOUT src_mask=%0b cycle=%0d", w_to_hit, r_cycle);
`endif
endmodule

// File: tb/tb_tlul_txn_monitor.sv
// Directed bench for tlul_txn_monitor: per-cycle vector table plus hand sequences for timeout and reset.
module tb_tlul_txn_monitor;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    tlul_pkg::tl_h2d_t  h2d;
    tlul_pkg::tl_d2h_t  d2h;
    logic [3:0]         outstanding;
    logic [31:0]        num_req, num_rsp, num_err;
    logic [15:0]        max_lat;
    logic               viol, tmo;
    logic [2:0]         code;

    int n_checks = 0;
    int n_fail   = 0;

    tlul_txn_monitor #(.NumSrc(4), .TimeoutCycles(16), .CntW(32), .LatW(16)) dut (
        .clk_i(clk), .rst_i(rst), .tl_h2d_i(h2d), .tl_d2h_i(d2h), .clear_i(clear),
        .outstanding_o(outstanding), .num_req_o(num_req), .num_rsp_o(num_rsp),
        .num_err_rsp_o(num_err), .max_latency_o(max_lat), .violation_o(viol),
        .violation_code_o(code), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a_v, a_r;
        logic [7:0] a_src;
        logic [31:0] a_addr;
        logic       d_v, d_r;
        logic [7:0] d_src;
        logic       d_err, clr;
        logic [3:0] e_out;
        int         e_req, e_rsp, e_err, e_lat;
        logic       e_viol;
        logic [2:0] e_code;
        logic       e_to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic av, logic ar, logic [7:0] as, logic [31:0] aa,
                                logic dv, logic dr, logic [7:0] ds, logic de, logic clr,
                                logic [3:0] eo, int erq, int ers, int eer, int elat,
                                logic ev, logic [2:0] ec);
        vec_t v;
        v.a_v = av; v.a_r = ar; v.a_src = as; v.a_addr = aa;
        v.d_v = dv; v.d_r = dr; v.d_src = ds; v.d_err = de; v.clr = clr;
        v.e_out = eo; v.e_req = erq; v.e_rsp = ers; v.e_err = eer; v.e_lat = elat;
        v.e_viol = ev; v.e_code = ec; v.e_to = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eo, input int erq, input int ers,
                           input int eer, input int elat, input logic ev, input logic [2:0] ec,
                           input logic eto);
        chk({tag, ".outstanding"}, 32'(outstanding), 32'(eo));
        chk({tag, ".num_req"}, num_req, erq);
        chk({tag, ".num_rsp"}, num_rsp, ers);
        chk({tag, ".num_err"}, num_err, eer);
        chk({tag, ".max_lat"}, 32'(max_lat), elat);
        chk({tag, ".violation"}, 32'(viol), 32'(ev));
        chk({tag, ".code"}, 32'(code), 32'(ec));
        chk({tag, ".timeout"}, 32'(tmo), 32'(eto));
    endtask

    task automatic drive(input logic av, input logic ar, input logic [7:0] as, input logic [31:0] aa,
                         input logic dv, input logic dr, input logic [7:0] ds, input logic de,
                         input logic clr);
        h2d = '0;
        d2h = '0;
        h2d.a_valid = av;  d2h.a_ready = ar;  h2d.a_source = as;  h2d.a_address = aa;
        d2h.d_valid = dv;  h2d.d_ready = dr;  d2h.d_source = ds;  d2h.d_error = de;
        clear = clr;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset_hold", 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Vector table: one entry per clock, expectations after the edge.
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,0, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,2,'h20,  0,1,0,0,0, 4'b0100,1,0,0,0,0,0));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0,0,0,0, 0,1,0,0,0, 4'b0100,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,     1,1,2,0,0, 4'b0000,1,1,0,7,0,0));
        tbl.push_back(mk(0,0,0,0,     1,0,2,0,0, 4'b0000,1,1,0,7,0,0));
        tbl.push_back(mk(1,1,0,'h0,   1,1,0,0,0, 4'b0000,2,2,0,7,0,0));
        tbl.push_back(mk(1,1,1,'h10,  0,1,0,0,0, 4'b0010,3,2,0,7,0,0));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(0,0,0,0, 0,1,0,0,0, 4'b0010,3,2,0,7,0,0));
        tbl.push_back(mk(1,1,1,'h14,  1,1,1,1,0, 4'b0010,4,3,1,7,0,0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0,0,0,0, 0,1,0,0,0, 4'b0010,4,3,1,7,0,0));
        tbl.push_back(mk(0,0,0,0,     1,1,1,0,0, 4'b0000,4,4,1,9,0,0));
        tbl.push_back(mk(1,1,3,'h30,  0,1,0,0,1, 4'b1000,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,     1,1,3,0,0, 4'b0000,0,1,0,1,0,0));
        tbl.push_back(mk(1,1,1,'h40,  0,1,0,0,0, 4'b0010,1,1,0,1,0,0));
        tbl.push_back(mk(1,1,1,'h44,  0,1,0,0,0, 4'b0010,2,1,0,1,1,2));
        tbl.push_back(mk(0,0,0,0,     1,1,0,0,0, 4'b0010,2,2,0,1,1,2));
        tbl.push_back(mk(0,0,0,0,     1,1,1,0,0, 4'b0000,2,3,0,2,1,2));
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,1, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,5,'h50,  0,1,0,0,0, 4'b0000,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,1, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,7,'h70,  1,1,0,0,0, 4'b0000,1,1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,1, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,'h100, 0,1,0,0,0, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,'h104, 0,1,0,0,0, 4'b0001,1,0,0,0,1,4));
        tbl.push_back(mk(0,0,0,0,     1,1,0,1,0, 4'b0000,1,1,1,1,1,4));
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,1, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,2,'h200, 0,1,0,0,0, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,0, 4'b0000,0,0,0,0,1,4));
        tbl.push_back(mk(0,0,0,0,     0,1,0,0,1, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,'h300, 0,1,0,0,0, 4'b0000,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,'h300, 0,1,0,0,0, 4'b0010,1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,     1,1,1,0,0, 4'b0000,1,1,0,1,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].a_v, tbl[i].a_r, tbl[i].a_src, tbl[i].a_addr,
                  tbl[i].d_v, tbl[i].d_r, tbl[i].d_src, tbl[i].d_err, tbl[i].clr);
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), tbl[i].e_out, tbl[i].e_req, tbl[i].e_rsp,
                    tbl[i].e_err, tbl[i].e_lat, tbl[i].e_viol, tbl[i].e_code, tbl[i].e_to);
        end

        // Timeout: request on source 3 never answered; flag rises 16 edges after the request edge.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
        drive(1, 1, 3, 'h330, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("to.req_pending", 32'(outstanding), 32'b1000);
        for (int j = 1; j <= 18; j++) begin
            idle_cycle();
            chk($sformatf("to.j%0d.timeout", j), 32'(tmo), (j >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("to.j%0d.code", j), 32'(code), (j >= 16) ? 32'd5 : 32'd0);
            chk($sformatf("to.j%0d.pending", j), 32'(outstanding), 32'b1000);
        end

        // Reset mid-transaction, then a late response on the discarded source.
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
        drive(1, 1, 1, 'h110, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("rst.pending", 32'(outstanding), 32'b1010);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_all("rst.async", 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();
        chk_all("rst.after", 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 0, 0);
        @(posedge clk); #1;
        chk_all("rst.late_rsp", 4'b0000, 0, 1, 0, 0, 1, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tlul_txn_monitor.md
# tlul_txn_monitor

Parametrised, passive TileLink-UL transaction monitor that sits beside a device port in a fuzzing/verification wrapper and observes the host-to-device and device-to-host channels without driving them. It tracks outstanding requests per source ID, counts requests, responses and error responses, and records the worst-case request-to-response latency. It also latches the first protocol violation: illegal source, duplicate source, unexpected response, A-channel instability, or timeout. It generalises a plain field-unpacking inspector into a stateful checker with configurable source count and timeout.

## Interface
Parameters:
- NumSrc, 4, number of tracked source IDs (0..NumSrc-1); SrcW = $clog2(NumSrc), min 1
- TimeoutCycles, 1024, per-source cycles pending before timeout (≥2)
- CntW, 32, width of event counters
- LatW, 16, width of latency counters and max_latency_o

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- tl_h2d_i  in  tlul_pkg::tl_h2d_t  observed host-to-device channel
- tl_d2h_i  in  tlul_pkg::tl_d2h_t  observed device-to-host channel
- clear_i  in  1  synchronous clear of counters, max latency and sticky flags
- outstanding_o  out  NumSrc  bit s = request from source s pending
- num_req_o  out  CntW  accepted A-channel beats
- num_rsp_o  out  CntW  accepted D-channel beats
- num_err_rsp_o  out  CntW  accepted D beats with d_error=1
- max_latency_o  out  LatW  largest completed latency
- violation_o  out  1  sticky, any violation seen
- violation_code_o  out  3  code of first violation
- timeout_o  out  1  sticky, any source timed out

## Operation
- req fire = a_valid & a_ready; rsp fire = d_valid & d_ready.
- Per-source state: IDLE / PENDING, plus LatW-bit latency counter.
- Req fire, source s: s ≥ NumSrc → code 1 ILLEGAL_SRC, no tracking; PENDING[s] → code 2 DUP_SRC, counter restarts at 0; else IDLE→PENDING, counter=0.
- Rsp fire, source s: PENDING → IDLE, candidate latency = counter+1; IDLE and no same-cycle req from s → code 3 UNEXPECTED_RSP; s ≥ NumSrc → code 1.
- Same-cycle req and rsp on same IDLE source: zero-latency completion, stays IDLE, candidate latency 0, no violation.
- Same-cycle req and rsp on same PENDING source: old txn completes, new txn starts (stays PENDING, counter=0), no violation.
- max_latency_o = max(max_latency_o, candidate) on each completion.
- PENDING counter increments per cycle, saturating at 2^LatW−1; counter reaching TimeoutCycles−1 → timeout_o=1, code 5 TIMEOUT, source stays PENDING.
- A-channel stability: registered a_valid & !a_ready; next cycle a_valid=0, or any of a_opcode/a_address/a_source/a_size/a_mask/a_data changed → code 4 A_UNSTABLE.
- violation_code_o latches only the first violation (lowest code wins on simultaneous violations); code 0 = none.
- Event counters saturate at all-ones.
- clear_i: counters, max_latency_o, violation_o, violation_code_o, timeout_o → 0; per-source PENDING state and latency counters retained. Same-cycle events are not counted.

## Timing
- Reset values: all outputs 0, all sources IDLE.
- All outputs registered; effects visible on the cycle after the triggering fire edge.
- Latency: req fire at cycle N, rsp fire at cycle N+k → latency k.
- Purely passive: no combinational path from inputs to outputs, no back-pressure.
- Reset asserted mid-transaction: pending state discarded; a later response for that source flags UNEXPECTED_RSP.

## Configuration
- TLUL_TXN_MONITOR_ASSERT_EN defined: concurrent SVA assertions raise $error at each violation type (codes 1-5), carrying source ID and cycle count. Assertions are disabled while rst_i is high.
- Undefined: no assertions; violations reported through output flags only. RTL behaviour is otherwise identical.

## Test plan
- Source 2 req at cycle 10, rsp at cycle 17 → outstanding_o[2] 1 during 11..17, max_latency_o=7, num_req_o=num_rsp_o=1, violation_o=0.
- Two reqs on source 1 without rsp → violation_code_o=2, violation_o=1; then UNEXPECTED_RSP on source 0 → code stays 2.
- TimeoutCycles=16, req on source 3, no rsp → timeout_o=1 and code 5 on cycle 16 after the req, outstanding_o[3] stays 1.
- a_valid=1, a_ready=0, a_address changes next cycle → code 4; rsp with d_error=1 → num_err_rsp_o increments.
- Same-cycle req+rsp on IDLE source 0 → no violation, max_latency_o unchanged at 0, both counters +1; clear_i then zeroes counters.
- rst_i asserted with source 1 PENDING, then rsp on source 1 → code 3 UNEXPECTED_RSP.
